ram_pipelined: RTL and testbench

//  Byte-addressable, little-endian RV32 data memory with a valid/ready request/response handshake.
//  It has parametrised depth and read latency.

---
 rtl/ram_pipelined_if.sv | 23 ++
 rtl/ram_pipelined.sv | 116 +++++++++++
 tb/tb_ram_pipelined.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_pipelined_if.sv
// rtl/ram_pipelined_if.sv - request/response handshake bundle for the pipelined data RAM
interface ram_pipelined_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_ctrl, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_ctrl, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/ram_pipelined.sv
// rtl/ram_pipelined.sv - byte-addressable little-endian RV32 data RAM, one outstanding access
module ram_pipelined #(
  parameter int DEPTH_BYTES  = 4096,
  parameter int READ_LATENCY = 1,
  parameter int ALIGN_CHECK  = 1
) (
  input  logic              Clock,
  input  logic              nReset,
  ram_pipelined_if.slave    bus
);
  localparam int          AW       = $clog2(DEPTH_BYTES);
  localparam logic [32:0] DEPTH33  = 33'(DEPTH_BYTES);
  localparam logic [1:0]  CNT_LAST = 2'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  mem [DEPTH_BYTES];

  logic          accept;
  logic          is_h, is_w, illegal, misalign, range_err, acc_err;
  logic [32:0]   last_byte;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_data;

  assign bus.req_ready = nReset & ((state_q == S_IDLE) | ((state_q == S_RESP) & bus.rsp_ready));
  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;

  assign is_h = (bus.req_ctrl[1:0] == 2'b01);
  assign is_w = (bus.req_ctrl[1:0] == 2'b10);
  assign illegal = (bus.req_ctrl == 3'b011) | (bus.req_ctrl == 3'b110) | (bus.req_ctrl == 3'b111) |
                   (bus.req_write & ((bus.req_ctrl == 3'b100) | (bus.req_ctrl == 3'b101)));
  assign misalign = (ALIGN_CHECK != 0) &
                    ((is_h & bus.req_addr[0]) | (is_w & (bus.req_addr[1:0] != 2'b00)));
  assign last_byte = {1'b0, bus.req_addr} + (is_w ? 33'd3 : (is_h ? 33'd1 : 33'd0));
  // Without alignment checks only the first byte must be in range; the rest wrap.
  assign range_err = (ALIGN_CHECK != 0) ? (last_byte >= DEPTH33)
                                        : ({1'b0, bus.req_addr} >= DEPTH33);
  assign acc_err = illegal | misalign | range_err;

  assign a0 = bus.req_addr[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    load_data = 32'h0;
    case (bus.req_ctrl)
      3'b000:  load_data = {{24{b0[7]}}, b0};
      3'b001:  load_data = {{16{b1[7]}}, b1, b0};
      3'b010:  load_data = {b3, b2, b1, b0};
      3'b100:  load_data = {24'h0, b0};
      3'b101:  load_data = {16'h0, b1, b0};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_RESP;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: ;
    endcase
    // Load data is captured at the accept edge so later stores cannot disturb it.
    if (accept) begin
      state_d = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
      cnt_d   = 2'd0;
      rdata_d = (bus.req_write | acc_err) ? 32'h0 : load_data;
      err_d   = acc_err;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (accept && bus.req_write && !acc_err) begin
      mem[a0] <= bus.req_wdata[7:0];
      if (is_h || is_w) mem[a1] <= bus.req_wdata[15:8];
      if (is_w) begin
        mem[a2] <= bus.req_wdata[23:16];
        mem[a3] <= bus.req_wdata[31:24];
      end
    end
  end
endmodule

// File: tb/tb_ram_pipelined.sv
// tb/tb_ram_pipelined.sv - directed self-checking bench for ram_pipelined
module tb_ram_pipelined;
  localparam int DEPTH = 4096;
  localparam int LAT   = 2;

  logic clk;
  logic n_reset;
  int   checks;
  int   errors;

  ram_pipelined_if bus();

  ram_pipelined #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT), .ALIGN_CHECK(1)) dut (
    .Clock  (clk),
    .nReset (n_reset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [2:0] c, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_ctrl  = c;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_error;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    checks = 0;
    errors = 0;
    n_reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_ctrl  = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'h0);
    n_reset = 1'b1;
    #1;
    check("idle_req_ready", 32'(bus.req_ready), 32'h1);

    // 1: word store then load
    xfer(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("sw_rdata", rd, 32'h0);
    check("sw_err", 32'(er), 32'h0);
    check("sw_lat", 32'(lat), 32'(LAT));
    xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'h0);
    check("lw_lat", 32'(lat), 32'(LAT));

    // 2: sub-word loads with sign/zero extension
    xfer(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
    check("lb_13", rd, 32'hFFFFFFDE);
    xfer(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
    check("lbu_13", rd, 32'h000000DE);
    xfer(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
    check("lh_12", rd, 32'hFFFFDEAD);
    xfer(1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat);
    check("lhu_10", rd, 32'h0000BEEF);
    xfer(1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
    check("lb_10_neg", rd, 32'hFFFFFFEF);

    // 3: byte store touches one byte only
    xfer(1'b1, 3'b000, 32'h11, 32'hAABBCC55, rd, er, lat);
    check("sb_err", 32'(er), 32'h0);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("lw_after_sb", rd, 32'hDEAD55EF);
    xfer(1'b1, 3'b001, 32'h22, 32'h99887766, rd, er, lat);
    xfer(1'b1, 3'b000, 32'h20, 32'h00000044, rd, er, lat);
    xfer(1'b1, 3'b000, 32'h21, 32'h00000033, rd, er, lat);
    xfer(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    check("lw_after_sh", rd, 32'h77663344);

    // 4: error cases leave memory untouched
    xfer(1'b1, 3'b010, 32'h21, 32'h12345678, rd, er, lat);
    check("sw_mis_err", 32'(er), 32'h1);
    check("sw_mis_rdata", rd, 32'h0);
    xfer(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    check("lw_after_mis", rd, 32'h77663344);
    check("lw_after_mis_err", 32'(er), 32'h0);
    xfer(1'b0, 3'b010, 32'(DEPTH - 2), 32'h0, rd, er, lat);
    check("lw_top_err", 32'(er), 32'h1);
    xfer(1'b0, 3'b010, 32'(DEPTH), 32'h0, rd, er, lat);
    check("lw_oor_err", 32'(er), 32'h1);
    xfer(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    check("ctrl011_err", 32'(er), 32'h1);
    check("ctrl011_rdata", rd, 32'h0);
    xfer(1'b1, 3'b100, 32'h10, 32'h000000FF, rd, er, lat);
    check("sbu_err", 32'(er), 32'h1);
    xfer(1'b0, 3'b101, 32'h11, 32'h0, rd, er, lat);
    check("lhu_mis_err", 32'(er), 32'h1);
    xfer(1'b1, 3'b000, 32'(DEPTH - 1), 32'h000000A5, rd, er, lat);
    check("sb_top_err", 32'(er), 32'h0);
    xfer(1'b0, 3'b000, 32'(DEPTH - 1), 32'h0, rd, er, lat);
    check("lb_top", rd, 32'hFFFFFFA5);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("lw_after_errs", rd, 32'hDEAD55EF);

    // 5: backpressure holds the response and blocks new requests
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_ctrl  = 3'b010;
    bus.req_addr  = 32'h10;
    @(posedge clk); #1;
    bus.req_addr  = 32'h20;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(bus.rsp_valid), 32'h1);
      check("hold_rdata", bus.rsp_rdata, 32'hDEAD55EF);
      check("hold_req_ready", 32'(bus.req_ready), 32'h0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release_req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("b2b_wait_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); #1;
    check("b2b_valid", 32'(bus.rsp_valid), 32'h1);
    check("b2b_rdata", bus.rsp_rdata, 32'h77663344);
    @(posedge clk); #1;

    // 6: reset during WAIT after a store, and during a held response
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_ctrl  = 3'b010;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_reset = 1'b0;
    #1;
    check("rst_wait_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_wait_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    check("rst_wait_valid2", 32'(bus.rsp_valid), 32'h0);
    n_reset = 1'b1;
    #1;
    xfer(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    check("lw_after_rst", rd, 32'hCAFEF00D);
    check("lw_after_rst_err", 32'(er), 32'h0);

    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h40;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(bus.rsp_valid), 32'h1);
    n_reset = 1'b0;
    #1;
    check("rst_resp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_resp_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check("post_rst_idle_ready", 32'(bus.req_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
